// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the sector responder.
package sd_resp_pkg;

    localparam int unsigned SECTOR_BYTES      = 512;
    localparam int unsigned SECTOR_SHIFT      = 9;
    localparam int unsigned ACK_DELAY_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RD_FETCH,
        RD_PUT,
        WR_ADDR,
        WR_CAP,
        WR_STORE,
        DONE
    } state_t;

endpackage

// File: rtl/sd_sector_responder_mount.sv
// Image mount status: captures mount requests into a pending slot and applies them when allowed.
module sd_mount_reg (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        mount_req,
    input  logic [63:0] mount_size,
    input  logic        mount_ro,
    input  logic        apply_en,
    output logic        pend,
    output logic [63:0] pend_size,
    output logic        pend_ro,
    output logic        img_mounted,
    output logic        img_readonly,
    output logic [63:0] img_size
);

    logic applied;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pend         <= 1'b0;
            pend_size    <= '0;
            pend_ro      <= 1'b0;
            applied      <= 1'b0;
            img_mounted  <= 1'b0;
            img_readonly <= 1'b0;
            img_size     <= '0;
        end else begin
            applied     <= 1'b0;
            img_mounted <= applied;
            if (apply_en && pend) begin
                img_size     <= pend_size;
                img_readonly <= pend_ro;
                applied      <= 1'b1;
            end
            // A new request always overwrites the slot, even on the cycle the old one is applied.
            if (mount_req) begin
                pend      <= 1'b1;
                pend_size <= mount_size;
                pend_ro   <= mount_ro;
            end else if (apply_en) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sd_sector_responder.sv
// Target side of the sector-transfer protocol, streaming 512-byte sectors to/from a byte-wide store.
module sd_sector_responder
    import sd_resp_pkg::*;
#(
    parameter int unsigned LBA_BITS  = 15,
    parameter int unsigned ACK_DELAY = ACK_DELAY_DEFAULT
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    output logic [8:0]            sd_buff_addr,
    output logic [7:0]            sd_buff_dout,
    output logic                  sd_buff_wr,
    input  logic [7:0]            sd_buff_din,
    input  logic                  mount_req,
    input  logic [63:0]           mount_size,
    input  logic                  mount_ro,
    output logic                  img_mounted,
    output logic                  img_readonly,
    output logic [63:0]           img_size,
    output logic [LBA_BITS+8:0]   st_addr,
    output logic                  st_rd,
    output logic                  st_wr,
    output logic [7:0]            st_dout,
    input  logic [7:0]            st_din,
    input  logic                  st_ack
);

    state_t              state;
    logic [LBA_BITS-1:0] lba;
    logic                is_rd;
    logic                valid;
    logic                wen;
    logic [3:0]          dly;
    logic                pend;
    logic                pend_ro;
    logic [63:0]         pend_size;
    logic [63:0]         eff_size;
    logic                eff_ro;
    logic                req_valid;
    logic                last;

    sd_mount_reg u_mount (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .mount_req    (mount_req),
        .mount_size   (mount_size),
        .mount_ro     (mount_ro),
        .apply_en     (state == IDLE),
        .pend         (pend),
        .pend_size    (pend_size),
        .pend_ro      (pend_ro),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size)
    );

    // A mount applied on the accept cycle governs the sector being accepted.
    always_comb begin
        eff_size  = pend ? pend_size : img_size;
        eff_ro    = pend ? pend_ro : img_readonly;
        req_valid = (eff_size != '0) && ({32'd0, sd_lba} < (eff_size >> SECTOR_SHIFT));
    end

    assign last    = (sd_buff_addr == 9'(SECTOR_BYTES - 1));
    assign st_addr = {lba, sd_buff_addr};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            lba          <= '0;
            is_rd        <= 1'b0;
            valid        <= 1'b0;
            wen          <= 1'b0;
            dly          <= '0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            st_rd        <= 1'b0;
            st_wr        <= 1'b0;
            st_dout      <= '0;
        end else begin
            sd_buff_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if ((sd_rd || sd_wr) && !sd_ack) begin
                        lba   <= sd_lba[LBA_BITS-1:0];
                        is_rd <= sd_rd;
                        valid <= req_valid;
                        wen   <= req_valid && !eff_ro;
                        dly   <= '0;
                        state <= DELAY;
                    end
                end
                DELAY: begin
                    if (dly == 4'(ACK_DELAY - 1)) begin
                        sd_ack       <= 1'b1;
                        sd_buff_addr <= '0;
                        if (is_rd) begin
                            st_rd <= valid;
                            state <= RD_FETCH;
                        end else begin
                            state <= WR_ADDR;
                        end
                    end else begin
                        dly <= dly + 4'd1;
                    end
                end
                RD_FETCH: begin
                    if (!valid) begin
                        sd_buff_dout <= '0;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUT;
                    end else if (st_ack) begin
                        sd_buff_dout <= st_din;
                        st_rd        <= 1'b0;
                        sd_buff_wr   <= 1'b1;
                        state        <= RD_PUT;
                    end
                end
                RD_PUT: begin
                    if (last) begin
                        state <= DONE;
                    end else begin
                        sd_buff_addr <= sd_buff_addr + 9'd1;
                        st_rd        <= valid;
                        state        <= RD_FETCH;
                    end
                end
                WR_ADDR: state <= WR_CAP;
                WR_CAP: begin
                    st_dout <= sd_buff_din;
                    if (wen) begin
                        st_wr <= 1'b1;
                        state <= WR_STORE;
                    end else if (last) begin
                        state <= DONE;
                    end else begin
                        sd_buff_addr <= sd_buff_addr + 9'd1;
                        state        <= WR_ADDR;
                    end
                end
                WR_STORE: begin
                    if (st_ack) begin
                        st_wr <= 1'b0;
                        if (last) begin
                            state <= DONE;
                        end else begin
                            sd_buff_addr <= sd_buff_addr + 9'd1;
                            state        <= WR_ADDR;
                        end
                    end
                end
                DONE: begin
                    sd_ack       <= 1'b0;
                    sd_buff_addr <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_responder.sv
// Directed bench for sd_sector_responder with a queue scoreboard of expected bytes.
module tb_sd_sector_responder;

    localparam int unsigned LBA_BITS  = 15;
    localparam int unsigned ACK_DELAY = 4;
    localparam int unsigned AW        = LBA_BITS + 9;

    logic          clk_sys      = 1'b0;
    logic          reset        = 1'b1;
    logic [31:0]   sd_lba       = '0;
    logic          sd_rd        = 1'b0;
    logic          sd_wr        = 1'b0;
    logic          sd_ack;
    logic [8:0]    sd_buff_addr;
    logic [7:0]    sd_buff_dout;
    logic          sd_buff_wr;
    logic [7:0]    sd_buff_din  = '0;
    logic          mount_req    = 1'b0;
    logic [63:0]   mount_size   = '0;
    logic          mount_ro     = 1'b0;
    logic          img_mounted;
    logic          img_readonly;
    logic [63:0]   img_size;
    logic [AW-1:0] st_addr;
    logic          st_rd;
    logic          st_wr;
    logic [7:0]    st_dout;
    logic [7:0]    st_din       = '0;
    logic          st_ack       = 1'b0;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    int wr_hs = 0;
    int st_rd_cycles = 0;
    int st_wr_cycles = 0;
    int both_cycles = 0;
    int mounted_cycles = 0;
    int st_wait = 0;
    bit stall_en = 1'b0;

    logic [16:0] rd_q[$];
    logic [31:0] wr_q[$];

    always #5 clk_sys = ~clk_sys;

    sd_sector_responder #(.LBA_BITS(LBA_BITS), .ACK_DELAY(ACK_DELAY)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mount_req    (mount_req),
        .mount_size   (mount_size),
        .mount_ro     (mount_ro),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .st_addr      (st_addr),
        .st_rd        (st_rd),
        .st_wr        (st_wr),
        .st_dout      (st_dout),
        .st_din       (st_din),
        .st_ack       (st_ack)
    );

    // Initiator sector RAM: one-cycle read latency.
    always @(posedge clk_sys) sd_buff_din <= sd_buff_addr[7:0] ^ 8'h5A;

    // Backing store: byte = addr[7:0] ^ lba[7:0], random ack latency, optional stall at byte 100 writes.
    always @(posedge clk_sys) begin
        if (reset) begin
            st_ack  <= 1'b0;
            st_wait <= 0;
        end else if (st_ack) begin
            st_ack <= 1'b0;
        end else if ((st_rd || st_wr) && !(stall_en && st_wr && sd_buff_addr == 9'd100)) begin
            if (st_wait == 0) begin
                st_ack  <= 1'b1;
                st_din  <= st_addr[7:0] ^ st_addr[16:9];
                st_wait <= $urandom_range(0, 2);
            end else begin
                st_wait <= st_wait - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and scored.
    task automatic step();
        @(posedge clk_sys);
        #1;
        if (!reset) begin
            if (sd_buff_wr) begin
                strobes++;
                checks++;
                assert (rd_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rd_unexpected: observed addr=%0h dout=%0h expected no strobe",
                           sd_buff_addr, sd_buff_dout);
                end
                if (rd_q.size() != 0) check("rd_byte", {sd_buff_addr, sd_buff_dout}, rd_q.pop_front());
            end
            if (st_wr && st_ack) begin
                wr_hs++;
                checks++;
                assert (wr_q.size() != 0) else begin
                    errors++;
                    $error("FAIL wr_unexpected: observed st_addr=%0h st_dout=%0h expected no write",
                           st_addr, st_dout);
                end
                if (wr_q.size() != 0) check("wr_byte", {st_addr, st_dout}, wr_q.pop_front());
            end
            if (st_rd) st_rd_cycles++;
            if (st_wr) st_wr_cycles++;
            if (st_rd && st_wr) both_cycles++;
            if (img_mounted) mounted_cycles++;
        end
    endtask

    task automatic wait_ack(input logic level, input int limit, output int n);
        n = 0;
        while (sd_ack !== level && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic push_read(input logic [31:0] lba, input bit valid);
        logic [8:0] a;
        for (int k = 0; k < 512; k++) begin
            a = 9'(k);
            rd_q.push_back({a, valid ? (a[7:0] ^ lba[7:0]) : 8'h00});
        end
    endtask

    task automatic push_write(input logic [31:0] lba);
        logic [8:0] a;
        for (int k = 0; k < 512; k++) begin
            a = 9'(k);
            wr_q.push_back({lba[LBA_BITS-1:0], a, a[7:0] ^ 8'h5A});
        end
    endtask

    task automatic do_mount(input logic [63:0] size, input logic ro, input string tag);
        int n;
        mount_size = size;
        mount_ro   = ro;
        mount_req  = 1'b1;
        step();
        mount_req  = 1'b0;
        n = 0;
        while (!img_mounted && n < 20) begin
            step();
            n++;
        end
        check({tag, "_pulse"}, img_mounted, 1);
        check({tag, "_size"}, img_size, size);
        check({tag, "_ro"}, img_readonly, ro);
        step();
        check({tag, "_pulse_len"}, img_mounted, 0);
    endtask

    task automatic run_read(input logic [31:0] lba, input bit valid, input logic also_wr, input string tag);
        int n, s0, r0, w0, ww0;
        push_read(lba, valid);
        s0 = strobes; r0 = st_rd_cycles; w0 = wr_hs; ww0 = st_wr_cycles;
        sd_lba = lba;
        sd_rd  = 1'b1;
        sd_wr  = also_wr;
        wait_ack(1'b1, 50, n);
        check({tag, "_ack_delay"}, n, ACK_DELAY + 1);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        wait_ack(1'b0, 8000, n);
        check({tag, "_ack_fall"}, sd_ack, 0);
        check({tag, "_strobes"}, strobes - s0, 512);
        check({tag, "_rd_q_empty"}, rd_q.size(), 0);
        check({tag, "_no_st_wr"}, st_wr_cycles - ww0 + wr_hs - w0, 0);
        if (!valid) check({tag, "_no_st_rd"}, st_rd_cycles - r0, 0);
    endtask

    task automatic run_write(input logic [31:0] lba, input bit wen, input string tag);
        int n, s0, h0, w0;
        if (wen) push_write(lba);
        s0 = strobes; h0 = wr_hs; w0 = st_wr_cycles;
        sd_lba = lba;
        sd_wr  = 1'b1;
        wait_ack(1'b1, 50, n);
        check({tag, "_ack_delay"}, n, ACK_DELAY + 1);
        sd_wr = 1'b0;
        wait_ack(1'b0, 8000, n);
        check({tag, "_ack_fall"}, sd_ack, 0);
        check({tag, "_handshakes"}, wr_hs - h0, wen ? 512 : 0);
        check({tag, "_wr_q_empty"}, wr_q.size(), 0);
        check({tag, "_no_strobes"}, strobes - s0, 0);
        if (!wen) begin
            check({tag, "_ack_len"}, n, 1025);
            check({tag, "_no_st_wr"}, st_wr_cycles - w0, 0);
        end
    endtask

    initial begin
        int n, m, s0, h0, mc0;

        repeat (3) step();
        check("rst_ack", sd_ack, 0);
        check("rst_buff", {sd_buff_wr, sd_buff_addr, sd_buff_dout}, 0);
        check("rst_store", {st_rd, st_wr}, 0);
        check("rst_img", {img_mounted, img_readonly, img_size}, 0);
        reset = 1'b0;
        step();

        do_mount(64'd32768, 1'b0, "m1");
        run_read(32'd3, 1'b1, 1'b0, "t1_read");
        check("t1_st_addr", st_addr, {15'd3, 9'd0});

        run_write(32'd63, 1'b1, "t2_write");

        do_mount(64'd0, 1'b0, "m2");
        run_read(32'd0, 1'b0, 1'b0, "t3_nosize");
        do_mount(64'd32768, 1'b0, "m3");
        run_read(32'd64, 1'b0, 1'b0, "t3_range");

        do_mount(64'd32768, 1'b1, "m4");
        run_write(32'd1, 1'b0, "t4_ro");

        // Back-to-back: second request raised in the DONE cycle.
        push_read(32'd5, 1'b1);
        s0 = strobes;
        sd_lba = 32'd5;
        sd_rd  = 1'b1;
        wait_ack(1'b1, 50, n);
        check("t5_ack_delay", n, ACK_DELAY + 1);
        sd_rd = 1'b0;
        n = 0;
        while (!(sd_buff_wr && sd_buff_addr == 9'd511) && n < 8000) begin
            step();
            n++;
        end
        check("t5_last", {sd_buff_wr, sd_buff_addr}, {1'b1, 9'd511});
        step();
        check("t5_done_ack", sd_ack, 1);
        push_read(32'd6, 1'b1);
        sd_lba = 32'd6;
        sd_rd  = 1'b1;
        step();
        check("t5_idle_gap", sd_ack, 0);
        wait_ack(1'b1, 50, m);
        check("t5_rearm", m + 1, ACK_DELAY + 2);
        sd_rd = 1'b0;
        wait_ack(1'b0, 8000, n);
        check("t5_ack_fall", sd_ack, 0);
        check("t5_strobes", strobes - s0, 1024);
        check("t5_rd_q_empty", rd_q.size(), 0);

        run_read(32'd2, 1'b1, 1'b1, "t6_both");

        // Mount arriving mid-sector is held until the sector completes.
        push_read(32'd4, 1'b1);
        sd_lba = 32'd4;
        sd_rd  = 1'b1;
        wait_ack(1'b1, 50, n);
        check("t7_ack_delay", n, ACK_DELAY + 1);
        sd_rd = 1'b0;
        n = 0;
        while (!(sd_buff_wr && sd_buff_addr == 9'd200) && n < 4000) begin
            step();
            n++;
        end
        check("t7_byte200", {sd_buff_wr, sd_buff_addr}, {1'b1, 9'd200});
        mc0 = mounted_cycles;
        mount_size = 64'd65536;
        mount_ro   = 1'b0;
        mount_req  = 1'b1;
        step();
        mount_req = 1'b0;
        wait_ack(1'b0, 8000, n);
        check("t7_ack_fall", sd_ack, 0);
        check("t7_no_early_mount", mounted_cycles - mc0, 0);
        check("t7_size_deferred", img_size, 64'd32768);
        check("t7_rd_q_empty", rd_q.size(), 0);
        n = 0;
        while (!img_mounted && n < 10) begin
            step();
            n++;
        end
        check("t7_mounted", img_mounted, 1);
        check("t7_new_size", {img_readonly, img_size}, {1'b0, 64'd65536});

        // Reset with a store write outstanding.
        push_write(32'd7);
        h0 = wr_hs;
        stall_en = 1'b1;
        sd_lba = 32'd7;
        sd_wr  = 1'b1;
        wait_ack(1'b1, 50, n);
        check("t8_ack_delay", n, ACK_DELAY + 1);
        sd_wr = 1'b0;
        n = 0;
        while (!(st_wr && sd_buff_addr == 9'd100) && n < 4000) begin
            step();
            n++;
        end
        repeat (3) step();
        check("t8_stalled", {st_wr, sd_buff_addr}, {1'b1, 9'd100});
        check("t8_partial", wr_hs - h0, 100);
        reset = 1'b1;
        step();
        check("t8_rst_ack", sd_ack, 0);
        check("t8_rst_st_wr", {st_rd, st_wr}, 0);
        check("t8_rst_addr", sd_buff_addr, 0);
        check("t8_rst_img", img_size, 0);
        wr_q.delete();
        stall_en = 1'b0;
        reset    = 1'b0;
        step();

        do_mount(64'd32768, 1'b0, "m5");
        run_write(32'd9, 1'b1, "t9_after_rst");

        check("rd_wr_exclusive", both_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Target end of the sector-transfer protocol used by the backup-RAM save/load logic.
- Services sd_rd/sd_wr sector requests by streaming 512-byte sectors over the sd_buff_* byte interface.
- Data comes from, or goes to, a local byte-wide backing store with a request/ack handshake.
- Also publishes image mount status (img_mounted/img_readonly/img_size). Used as an on-FPGA save store and as the bench model for initiator blocks.

Parameters:
LBA_BITS, 15, number of LBA bits forwarded to the store address; store address width = LBA_BITS+9
ACK_DELAY, 4, cycles from accepting a request to asserting sd_ack (1..15)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
sd_lba  in  32  sector number, sampled on request accept
sd_rd  in  1  read request (level)
sd_wr  in  1  write request (level)
sd_ack  out  1  high for the whole transfer
sd_buff_addr  out  9  byte index within sector
sd_buff_dout  out  8  read data to initiator
sd_buff_wr  out  1  one-cycle strobe; sd_buff_dout valid at sd_buff_addr
sd_buff_din  in  8  write data from initiator; 1-cycle latency after sd_buff_addr
mount_req  in  1  pulse: new image present
mount_size  in  64  image size in bytes, sampled with mount_req
mount_ro  in  1  read-only flag, sampled with mount_req
img_mounted  out  1  one-cycle pulse after mount is applied
img_readonly  out  1  current read-only flag
img_size  out  64  current image size (0 = no image)
st_addr  out  LBA_BITS+9  {sd_lba[LBA_BITS-1:0], sd_buff_addr}
st_rd  out  1  store read request, held until st_ack
st_wr  out  1  store write request, held until st_ack
st_dout  out  8  store write data
st_din  in  8  store read data, valid with st_ack
st_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset values: sd_ack=0, sd_buff_wr=0, sd_buff_addr=0, sd_buff_dout=0, st_rd=0, st_wr=0, img_mounted=0, img_readonly=0, img_size=0. State=IDLE. Pending mount is cleared.
- States: IDLE, DELAY, RD_FETCH, RD_PUT, WR_ADDR, WR_CAP, WR_STORE, DONE.
- IDLE: if sd_rd|sd_wr and sd_ack=0, latch sd_lba and direction, then go to DELAY.
  - sd_rd wins if both are high.
  - Set valid = (img_size!=0) && (sd_lba < img_size>>9).
  - Write enable = valid && !img_readonly.
- DELAY: count ACK_DELAY cycles, then set sd_ack=1 and sd_buff_addr=0. Go to RD_FETCH or WR_ADDR.
- RD_FETCH:
  - If valid: hold st_rd=1 until st_ack, capture st_din into sd_buff_dout.
  - If not valid: load 0x00 in one cycle with no store access.
  - Then go to RD_PUT.
- RD_PUT: sd_buff_wr=1 for exactly one cycle.
  - If sd_buff_addr=511, go to DONE.
  - Otherwise increment sd_buff_addr and go to RD_FETCH.
- WR_ADDR: one cycle holding sd_buff_addr, covering initiator RAM latency. Then go to WR_CAP.
- WR_CAP: capture sd_buff_din into st_dout.
  - If write enabled, go to WR_STORE.
  - If not, discard the byte and advance the same way as WR_STORE completion.
- WR_STORE: hold st_wr=1 until st_ack.
  - If addr=511, go to DONE.
  - Otherwise increment addr and go to WR_ADDR.
- DONE: sd_ack=0 and sd_buff_addr=0, then go to IDLE.
  - A request already high in IDLE is accepted the cycle after DONE.
  - The initiator drops sd_rd/sd_wr on the sd_ack rise and re-raises them for the next sector.
- st_addr is combinational from the latched LBA and sd_buff_addr. st_rd and st_wr are never high together.
- Mount handling:
  - A mount_req pulse captures mount_size/mount_ro into a pending slot; the latest capture wins.
  - Pending mounts are applied only in IDLE: update img_size and img_readonly, then pulse img_mounted on the next cycle.
  - A mount that arrives mid-transfer is deferred. The in-flight sector keeps its latched valid/write-enable.
- Requests are ignored while sd_ack=1. Address wraps only via the 511 terminal check; it never counts past 511.
- Reset mid-transfer: next cycle all outputs return to reset values and any outstanding st_ack is ignored.
- No timeout on st_ack: a stalled store stalls the transfer.

Decomposition:
- Shared package sd_resp_pkg holds:
  - state enum typedef;
  - SECTOR_BYTES=512 and SECTOR_SHIFT=9;
  - ACK_DELAY default.
- No sub-module is required. The mount pending/apply logic may be split into sd_mount_reg (~40 lines) if that reads more clearly.

Test Plan:
- Store read path: mount 32768 bytes rw, store byte[k]=k[7:0]^lba, sd_rd with lba=3. Required: sd_ack rises ACK_DELAY cycles after accept, exactly 512 sd_buff_wr strobes with addr 0..511 and dout=k^3, then sd_ack falls and st_addr top bits = 3.
- Store write path: sd_wr with lba=63, initiator RAM returns addr^0x5A one cycle after addr. Required: 512 st_wr handshakes, st_addr={63,k}, st_dout=k^0x5A, no sd_buff_wr.
- Out-of-range read: img_size=0 then sd_rd with lba=0. Required: 512 strobes of 0x00 and st_rd never asserted. Repeat with size=32768 and lba=64: same result.
- Read-only write: mount_ro=1, sd_wr with lba=1. Required: full 512-step sd_ack cycle and st_wr never asserted.
- Back-to-back and simultaneous requests:
  - The initiator re-raises sd_rd during DONE; the second transfer must start with no lost cycle beyond the single IDLE cycle.
  - With sd_rd and sd_wr raised together, the block must perform a read.
- Mount deferral and reset: mount_req during byte 200 of a read → img_mounted pulses only after DONE. Assert reset at byte 100 of a write with st_wr pending → sd_ack=0 and st_wr=0 next cycle, and a fresh request completes normally.
